// File: rtl/multi_tc_sched.sv
// Three-channel periodic timer scheduler sharing one free-running prescaler,
// with a round-robin arbiter that multiplexes the channel event counts onto one LED bus.
module multi_tc_sched #(
  parameter int M  = 35,
  parameter int R  = 7,
  parameter int S0 = 19,
  parameter int S1 = 23,
  parameter int S2 = 27,
  parameter int SD = 26
) (
  input  logic         clk,
  input  logic         notrst,
  input  logic [2:0]   en,
  input  logic [R:0]   dipsw0,
  input  logic [R:0]   dipsw1,
  input  logic [R:0]   dipsw2,
  output logic [2:0]   evt,
  output logic [R:0]   ioled0,
  output logic [R:0]   ioled1,
  output logic [R:0]   ioled2,
  output logic [R:0]   led,
  output logic [1:0]   dsel
);

  localparam logic [M:0] PS_ONE = {{M{1'b0}}, 1'b1};
  localparam logic [R:0] ONE    = {{R{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  logic [M:0] ps;
  logic [3:0] tap_now;
  logic [3:0] tap_prev;
  logic [3:0] tick;

  state_t     state  [3];
  logic [R:0] cnt    [3];
  logic [R:0] ecount [3];
  logic [R:0] period [3];

  logic [3:0] enx;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] next_sel;

  // Bit order: channel 0..2 ticks in [2:0], display-advance tick in [3].
  assign tap_now = {ps[SD], ps[S2], ps[S1], ps[S0]};
  assign tick    = tap_now & ~tap_prev;

  assign period[0] = dipsw0;
  assign period[1] = dipsw1;
  assign period[2] = dipsw2;

  assign ioled0 = ecount[0];
  assign ioled1 = ecount[1];
  assign ioled2 = ecount[2];

  always_ff @(posedge clk or negedge notrst) begin
    if (!notrst) begin
      ps       <= '0;
      tap_prev <= '0;
    end else begin
      ps       <= ps + PS_ONE;
      tap_prev <= tap_now;
    end
  end

  // Disable wins over everything, including a tick on the same cycle.
  always_ff @(posedge clk or negedge notrst) begin
    if (!notrst) begin
      evt <= '0;
      for (int i = 0; i < 3; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= '0;
        ecount[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        evt[i] <= 1'b0;
        if (!en[i]) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
        end else begin
          case (state[i])
            IDLE: begin
              cnt[i]   <= period[i];
              state[i] <= (period[i] != '0) ? RUN : HALT;
            end
            RUN: begin
              if (tick[i]) begin
                if (cnt[i] > ONE) begin
                  cnt[i] <= cnt[i] - ONE;
                end else begin
                  evt[i]    <= 1'b1;
                  ecount[i] <= ecount[i] + ONE;
                  cnt[i]    <= period[i];
                  if (period[i] == '0) state[i] <= HALT;
                end
              end
            end
            HALT: begin
              if (period[i] != '0) begin
                cnt[i]   <= period[i];
                state[i] <= RUN;
              end
            end
            default: begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Search order dsel+1, dsel+2, then dsel itself, all modulo 3.
  assign enx = {1'b0, en};

  always_comb begin
    cand1    = (dsel == 2'd2) ? 2'd0 : dsel + 2'd1;
    cand2    = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    next_sel = dsel;
    if (enx[cand1])      next_sel = cand1;
    else if (enx[cand2]) next_sel = cand2;
  end

  always_ff @(posedge clk or negedge notrst) begin
    if (!notrst) dsel <= 2'd0;
    else if (tick[3]) dsel <= next_sel;
  end

  always_comb begin
    led = '0;
    case (dsel)
      2'd0:    if (en[0]) led = ecount[0];
      2'd1:    if (en[1]) led = ecount[1];
      2'd2:    if (en[2]) led = ecount[2];
      default: led = '0;
    endcase
  end

endmodule
